// File: rtl/window_gen.sv
// window_gen: streaming 3x3 neighbourhood generator for raster-order pixels.
//
// Two line buffers (read-first, addressed by column) supply the two previous
// lines; a 3x3 shift array forms the window one column per accepted pixel.
// Only interior windows are emitted (no border padding), so a frame yields
// (IMG_W-2)*(IMG_H-2) windows, centre = (x-1, y-1) of the completing pixel.
//
// Optional build macro WINDOW_GEN_OUT_REG_EN: adds one output register stage
// (latency 3 instead of 2 from the accepting edge); content and order unchanged.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (line buffers are not cleared)
//   pix_valid  pixel accepted this cycle, no backpressure
//   pix_in     raster-order pixel
//   sof        start of frame, qualified by pix_valid
//   win        3x3 window, element (r,c) at [DATA_W*(3r+c) +: DATA_W],
//              r=0 oldest line, c=0 oldest column
//   win_valid  win/win_x/win_y valid this cycle
//   win_x      window centre column
//   win_y      window centre line
//   frame_done one-cycle pulse with the last window of a frame
module window_gen #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned IMG_H  = 480,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid,
    input  logic [DATA_W-1:0]     pix_in,
    input  logic                  sof,
    output logic [9*DATA_W-1:0]   win,
    output logic                  win_valid,
    output logic [ADDR_W-1:0]     win_x,
    output logic [15:0]           win_y,
    output logic                  frame_done
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned WIN_W = 9*DATA_W;
    localparam int unsigned Y_W   = 16;

    // Raster position counters
    logic [ADDR_W-1:0] x_q;
    logic [Y_W-1:0]    y_q;

    // Position of the pixel presented this cycle (sof with pix_valid forces origin)
    logic [ADDR_W-1:0] cur_x_c;
    logic [Y_W-1:0]    cur_y_c;
    logic              line_end_c;
    logic              frame_end_c;
    logic              emit_c;

    always_comb begin
        cur_x_c     = x_q;
        cur_y_c     = y_q;
        if (pix_valid && sof) begin
            cur_x_c = '0;
            cur_y_c = '0;
        end
        line_end_c  = (cur_x_c == ADDR_W'(IMG_W-1));
        frame_end_c = line_end_c && (cur_y_c == Y_W'(IMG_H-1));
        emit_c      = pix_valid && (cur_x_c >= ADDR_W'(2)) && (cur_y_c >= Y_W'(2));
    end

    // Counter advance on every accepted pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (pix_valid) begin
            if (line_end_c) begin
                x_q <= '0;
                y_q <= frame_end_c ? '0 : cur_y_c + Y_W'(1);
            end else begin
                x_q <= cur_x_c + ADDR_W'(1);
                y_q <= cur_y_c;
            end
        end
    end

    // Line buffers: line0 = previous line, line1 = line before that
    logic [DATA_W-1:0] line0_mem [DEPTH];
    logic [DATA_W-1:0] line1_mem [DEPTH];
    logic [DATA_W-1:0] rd0_q;
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] pix_d_q;

    // Read-first access: old contents are read while line0 shifts into line1
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            rd0_q              <= line0_mem[cur_x_c];
            rd1_q              <= line1_mem[cur_x_c];
            line0_mem[cur_x_c] <= pix_in;
            line1_mem[cur_x_c] <= line0_mem[cur_x_c];
            pix_d_q            <= pix_in;
        end
    end

    // Stage 1 control, aligned with the buffer read data
    logic              s1_shift_q;
    logic              s1_emit_q;
    logic              s1_last_q;
    logic [ADDR_W-1:0] s1_x_q;
    logic [Y_W-1:0]    s1_y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_shift_q <= 1'b0;
            s1_emit_q  <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
        end else begin
            s1_shift_q <= pix_valid;
            s1_emit_q  <= emit_c;
            s1_last_q  <= emit_c && frame_end_c;
            if (emit_c) begin
                s1_x_q <= cur_x_c - ADDR_W'(1);
                s1_y_q <= cur_y_c - Y_W'(1);
            end
        end
    end

    // 3x3 shift array: column 2 is newest, row 2 is the current line
    logic [DATA_W-1:0] sr_q [3][3];

    always_ff @(posedge clk) begin
        if (s1_shift_q) begin
            for (int r = 0; r < 3; r++) begin
                sr_q[r][0] <= sr_q[r][1];
                sr_q[r][1] <= sr_q[r][2];
            end
            sr_q[0][2] <= rd1_q;
            sr_q[1][2] <= rd0_q;
            sr_q[2][2] <= pix_d_q;
        end
    end

    // Stage 2 control, aligned with the shift array contents
    logic              s2_emit_q;
    logic              s2_last_q;
    logic [ADDR_W-1:0] s2_x_q;
    logic [Y_W-1:0]    s2_y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_emit_q <= 1'b0;
            s2_last_q <= 1'b0;
            s2_x_q    <= '0;
            s2_y_q    <= '0;
        end else begin
            s2_emit_q <= s1_emit_q;
            s2_last_q <= s1_last_q;
            s2_x_q    <= s1_x_q;
            s2_y_q    <= s1_y_q;
        end
    end

    // Flatten the shift array into the output word layout
    logic [WIN_W-1:0] win_pack_c;

    always_comb begin
        win_pack_c = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_pack_c[DATA_W*(3*r+c) +: DATA_W] = sr_q[r][c];
            end
        end
    end

    // Window output register; payload holds while no window is emitted
    logic [WIN_W-1:0]  win_q;
    logic              win_valid_q;
    logic [ADDR_W-1:0] win_x_q;
    logic [Y_W-1:0]    win_y_q;
    logic              frame_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            win_valid_q  <= s2_emit_q;
            frame_done_q <= s2_last_q;
            if (s2_emit_q) begin
                win_q   <= win_pack_c;
                win_x_q <= s2_x_q;
                win_y_q <= s2_y_q;
            end
        end
    end

`ifdef WINDOW_GEN_OUT_REG_EN
    // Extra retiming stage for timing closure at the consumer
    always_ff @(posedge clk) begin
        if (rst) begin
            win        <= '0;
            win_valid  <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            win        <= win_q;
            win_valid  <= win_valid_q;
            win_x      <= win_x_q;
            win_y      <= win_y_q;
            frame_done <= frame_done_q;
        end
    end
`else
    assign win        = win_q;
    assign win_valid  = win_valid_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: directed bench for window_gen on a 4x4 image.
// A frame-image model predicts every window (content, centre, frame_done,
// timing); literal expectations pin the model on the reference frames.
module tb_window_gen;

    localparam int unsigned DW = 8;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned AW = 2;
`ifdef WINDOW_GEN_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            pix_valid;
    logic [DW-1:0]   pix_in;
    logic            sof;
    logic [9*DW-1:0] win;
    logic            win_valid;
    logic [AW-1:0]   win_x;
    logic [15:0]     win_y;
    logic            frame_done;

    window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_in(pix_in), .sof(sof),
        .win(win), .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              due;
        int              acc;
        logic [9*DW-1:0] w;
        int              x;
        int              y;
        bit              fd;
    } exp_t;

    typedef struct {
        logic [9*DW-1:0] w;
        int              x;
        int              y;
        bit              fd;
        int              d;
    } log_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    exp_t q[$];
    log_t win_log[$];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Model: image of the current frame plus raster position
    int              img [H][W];
    int              mx = 0;
    int              my = 0;
    int              cyc = 0;
    logic [9*DW-1:0] hold_w = '0;

    always @(posedge clk) begin
        int   cx, cy;
        exp_t e;
        if (rst) begin
            mx = 0;
            my = 0;
            q.delete();
            hold_w = '0;
        end else if (pix_valid) begin
            cx = sof ? 0 : mx;
            cy = sof ? 0 : my;
            img[cy][cx] = int'(pix_in);
            if (cx >= 2 && cy >= 2) begin
                e.w = '0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        e.w[DW*(3*r+c) +: DW] = DW'(img[cy-2+r][cx-2+c]);
                e.acc = cyc;
                e.due = cyc + LAT + 1;
                e.x   = cx - 1;
                e.y   = cy - 1;
                e.fd  = (cx == W-1) && (cy == H-1);
                q.push_back(e);
            end
            mx = cx + 1;
            my = cy;
            if (mx == W) begin
                mx = 0;
                my = (cy + 1) % H;
            end
        end
        cyc = cyc + 1;
        #1;
        if (chk_en) begin
            if (win_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_win_valid", 128'(win_valid), 128'(0));
                end else begin
                    e = q.pop_front();
                    chk("win_timing", 128'(cyc), 128'(e.due));
                    chk("win", 128'(win), 128'(e.w));
                    chk("win_x", 128'(win_x), 128'(e.x));
                    chk("win_y", 128'(win_y), 128'(e.y));
                    chk("frame_done", 128'(frame_done), 128'(e.fd));
                    win_log.push_back('{w: win, x: int'(win_x), y: int'(win_y),
                                        fd: frame_done, d: cyc - 1 - e.acc});
                end
                hold_w = win;
            end else begin
                chk("frame_done_idle", 128'(frame_done), 128'(0));
                chk("win_hold", 128'(win), 128'(hold_w));
                if (q.size() > 0 && q[0].due <= cyc) begin
                    chk("missed_window", 128'(0), 128'(1));
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic px(input int d, input bit s);
        pix_valid = 1'b1;
        pix_in    = DW'(d);
        sof       = s;
        @(negedge clk);
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic frame(input int base, input int gap);
        for (int i = 0; i < W*H; i++) begin
            px(base + i, i == 0);
            idle(gap);
        end
    endtask

    localparam logic [71:0] WIN0   = 72'h0A_09_08_06_05_04_02_01_00;
    localparam logic [71:0] WIN100 = 72'h6E_6D_6C_6A_69_68_66_65_64;
    localparam logic [71:0] WIN50  = 72'h3C_3B_3A_38_37_36_34_33_32;

    int   base;
    int   ref_x [4] = '{1, 2, 1, 2};
    int   ref_y [4] = '{1, 1, 2, 2};
    log_t ref_win [4];

    initial begin
        rst = 1'b1; pix_valid = 1'b0; pix_in = '0; sof = 1'b0;
        idle(3);
        chk("rst_win", 128'(win), 128'(0));
        chk("rst_win_valid", 128'(win_valid), 128'(0));
        chk("rst_win_x", 128'(win_x), 128'(0));
        chk("rst_win_y", 128'(win_y), 128'(0));
        chk("rst_frame_done", 128'(frame_done), 128'(0));
        rst = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // Continuous reference frame 4y+x
        base = win_log.size();
        frame(0, 0);
        idle(6);
        chk("t1_count", 128'(win_log.size() - base), 128'(4));
        if (win_log.size() - base == 4) begin
            chk("t1_first_win", 128'(win_log[base].w), 128'(WIN0));
            chk("t1_first_latency", 128'(win_log[base].d), 128'(LAT));
            for (int i = 0; i < 4; i++) begin
                ref_win[i] = win_log[base + i];
                chk("t1_centre_x", 128'(win_log[base + i].x), 128'(ref_x[i]));
                chk("t1_centre_y", 128'(win_log[base + i].y), 128'(ref_y[i]));
                chk("t1_frame_done", 128'(win_log[base + i].fd), 128'(i == 3));
            end
        end

        // Same frame, 1-on/2-off valid pattern
        base = win_log.size();
        frame(0, 2);
        idle(6);
        chk("t2_count", 128'(win_log.size() - base), 128'(4));
        if (win_log.size() - base == 4) begin
            chk("t2_first_win", 128'(win_log[base].w), 128'(WIN0));
            for (int i = 0; i < 4; i++) begin
                chk("t2_same_win", 128'(win_log[base + i].w), 128'(ref_win[i].w));
                chk("t2_latency", 128'(win_log[base + i].d), 128'(LAT));
            end
        end

        // Reset after pixel 9, then a fresh frame 100+4y+x
        base = win_log.size();
        for (int i = 0; i < 10; i++) px(i, i == 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("t3_no_window_before_rst", 128'(win_log.size() - base), 128'(0));
        frame(100, 0);
        idle(6);
        chk("t3_count", 128'(win_log.size() - base), 128'(4));
        if (win_log.size() > base)
            chk("t3_first_win", 128'(win_log[base].w), 128'(WIN100));

        // sof re-asserted at pixel 6
        base = win_log.size();
        for (int i = 0; i < 6; i++) px(200 + i, i == 0);
        frame(50, 0);
        idle(6);
        chk("t4_count", 128'(win_log.size() - base), 128'(4));
        if (win_log.size() > base) begin
            chk("t4_first_win", 128'(win_log[base].w), 128'(WIN50));
            chk("t4_first_x", 128'(win_log[base].x), 128'(1));
            chk("t4_first_y", 128'(win_log[base].y), 128'(1));
        end

        // Two back-to-back frames (counter wrap), random gaps, stray sof without valid
        base = win_log.size();
        for (int i = 0; i < 2*W*H; i++) begin
            px(int'($urandom_range(0, 255)), i == 0);
            repeat ($urandom_range(0, 3)) begin
                sof = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                sof = 1'b0;
            end
        end
        idle(6);
        chk("t5_count", 128'(win_log.size() - base), 128'(8));
        chk("drain_empty", 128'(q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
